// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and the RGB565 -> RGB444 slice used by
// the sprite scanner and its timing generator.
package vga_timing_pkg;

    localparam int CNT_W = 12;

    localparam int PIX_DIV_DEFAULT     = 4;
    localparam int SCALE_SHIFT_DEFAULT = 2;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Keep the top 4 bits of each RGB565 field.
    function automatic rgb444_t rgb565_to_444(input logic [15:0] d);
        rgb444_t c;
        c.r = d[15:12];
        c.g = d[10:7];
        c.b = d[4:1];
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider plus horizontal/vertical raster counters; exposes the
// counters' next values and the raw per-pixel active/sync/wrap flags.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV  = PIX_DIV_DEFAULT,
    parameter int H_ACT    = H_ACTIVE,
    parameter int H_FRONT  = H_FP,
    parameter int H_SW     = H_SYNC,
    parameter int H_BACK   = H_BP,
    parameter int V_ACT    = V_ACTIVE,
    parameter int V_FRONT  = V_FP,
    parameter int V_SW     = V_SYNC,
    parameter int V_BACK   = V_BP
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [CNT_W-1:0] h_next,
    output logic [CNT_W-1:0] v_next,
    output logic             active,
    output logic             hsync_n,
    output logic             vsync_n,
    output logic             frame_wrap
);

    localparam int DIV_W  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int H_TOT  = H_ACT + H_FRONT + H_SW + H_BACK;
    localparam int V_TOT  = V_ACT + V_FRONT + V_SW + V_BACK;
    localparam int HS_BEG = H_ACT + H_FRONT;
    localparam int HS_END = HS_BEG + H_SW;
    localparam int VS_BEG = V_ACT + V_FRONT;
    localparam int VS_END = VS_BEG + V_SW;

    logic [DIV_W-1:0] div_cnt_reg;
    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic             h_last;
    logic             v_last;

    assign tick   = (div_cnt_reg == DIV_W'(PIX_DIV - 1));
    assign h_last = (h_cnt_reg == CNT_W'(H_TOT - 1));
    assign v_last = (v_cnt_reg == CNT_W'(V_TOT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
        end else begin
            div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
            if (tick) begin
                h_cnt_reg <= h_next;
                v_cnt_reg <= v_next;
            end
        end
    end

    // Next raster position, independent of tick so the top can preload addresses.
    always_comb begin
        h_next = h_cnt_reg + 1'b1;
        v_next = v_cnt_reg;
        if (h_last) begin
            h_next = '0;
            v_next = v_last ? '0 : v_cnt_reg + 1'b1;
        end
    end

    assign active     = (h_cnt_reg < CNT_W'(H_ACT)) && (v_cnt_reg < CNT_W'(V_ACT));
    assign hsync_n    = !((h_cnt_reg >= CNT_W'(HS_BEG)) && (h_cnt_reg < CNT_W'(HS_END)));
    assign vsync_n    = !((v_cnt_reg >= CNT_W'(VS_BEG)) && (v_cnt_reg < CNT_W'(VS_END)));
    assign frame_wrap = tick && h_last && v_last;

endmodule

// File: rtl/vga_sprite_scan.sv
// Scans the sprite store at a downscaled resolution and drives VGA RGB444 plus
// sync, with colour and sync both delayed one pixel behind the address.
module vga_sprite_scan
    import vga_timing_pkg::*;
#(
    parameter int PIX_DIV     = PIX_DIV_DEFAULT,
    parameter int SCALE_SHIFT = SCALE_SHIFT_DEFAULT,
    parameter int H_ACT       = H_ACTIVE,
    parameter int H_FRONT     = H_FP,
    parameter int H_SW        = H_SYNC,
    parameter int H_BACK      = H_BP,
    parameter int V_ACT       = V_ACTIVE,
    parameter int V_FRONT     = V_FP,
    parameter int V_SW        = V_SYNC,
    parameter int V_BACK      = V_BP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  ram_addr_x,
    output logic [7:0]  ram_addr_y,
    input  logic [15:0] ram_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    logic             tick;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             active;
    logic             hsync_n;
    logic             vsync_n;
    logic             frame_wrap;
    rgb444_t          pix_raw;
    logic [11:0]      pix_gated;

    vga_timing_gen #(
        .PIX_DIV (PIX_DIV),
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .H_SW    (H_SW),
        .H_BACK  (H_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT),
        .V_SW    (V_SW),
        .V_BACK  (V_BACK)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .h_next     (h_next),
        .v_next     (v_next),
        .active     (active),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .frame_wrap (frame_wrap)
    );

    assign pix_raw = rgb565_to_444(ram_data);

    genvar gi;
    generate
        for (gi = 0; gi < 12; gi++) begin : g_blank
            assign pix_gated[gi] = pix_raw[gi] & active;
        end
    endgenerate

    // Addresses track the pixel being fetched; colour/sync track the pixel just fetched.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_x  <= '0;
            ram_addr_y  <= '0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                ram_addr_x <= 8'(h_next >> SCALE_SHIFT);
                ram_addr_y <= 8'(v_next >> SCALE_SHIFT);
                vga_r      <= pix_gated[11:8];
                vga_g      <= pix_gated[7:4];
                vga_b      <= pix_gated[3:0];
                hsync      <= hsync_n;
                vsync      <= vsync_n;
            end
        end
    end

endmodule

// File: tb/tb_vga_sprite_scan.sv
// Randomized-reset bench for vga_sprite_scan on a shrunken raster, checked every
// cycle against a time-based model (pixel = elapsed cycles / PIX_DIV).
module tb_vga_sprite_scan;

    localparam int PD = 4;
    localparam int SS = 2;
    localparam int HA = 40, HF = 4, HS = 8, HB = 4;
    localparam int VA = 20, VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;   // 56
    localparam int VT = VA + VF + VS + VB;   // 27
    localparam int FRAME = PD * HT * VT;     // 6048

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ram_addr_x;
    logic [7:0]  ram_addr_y;
    logic [15:0] ram_data;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    logic [15:0] mem [0:4095];

    int  t = 0;
    int  checks = 0;
    int  passes = 0;
    bit  started = 1'b0;
    int  cyc = 0;
    int  last_fs = -1;
    int  fs_count = 0;
    int  hs_run = 0;
    int  vs_run = 0;

    vga_sprite_scan #(
        .PIX_DIV     (PD),
        .SCALE_SHIFT (SS),
        .H_ACT       (HA),
        .H_FRONT     (HF),
        .H_SW        (HS),
        .H_BACK      (HB),
        .V_ACT       (VA),
        .V_FRONT     (VF),
        .V_SW        (VS),
        .V_BACK      (VB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_addr_x  (ram_addr_x),
        .ram_addr_y  (ram_addr_y),
        .ram_data    (ram_data),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    assign ram_data = mem[{ram_addr_y[5:0], ram_addr_x[5:0]}];

    // Cycles elapsed since the last reset edge.
    always @(posedge clk) t <= rst ? 0 : t + 1;

    task automatic summary();
        $display("%0d/%0d checks passed", passes, checks);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
            if (checks - passes >= 50) begin
                summary();
                $finish;
            end
        end
    endtask

    // Per-cycle comparison against the raster model.
    always @(negedge clk) begin
        int n, h, v, hp, vp, er, eg, eb, ehs, evs, efs;
        logic [15:0] d;
        if (started) begin
            n = t / PD;
            h = n % HT;
            v = (n / HT) % VT;
            er = 0; eg = 0; eb = 0; ehs = 1; evs = 1;
            if (n > 0) begin
                hp = (n - 1) % HT;
                vp = ((n - 1) / HT) % VT;
                d  = mem[(vp >> SS) * 64 + (hp >> SS)];
                if (hp < HA && vp < VA) begin
                    er = int'(d[15:12]);
                    eg = int'(d[10:7]);
                    eb = int'(d[4:1]);
                end
                ehs = (hp >= HA + HF && hp < HA + HF + HS) ? 0 : 1;
                evs = (vp >= VA + VF && vp < VA + VF + VS) ? 0 : 1;
            end
            efs = (t != 0 && t % FRAME == 0) ? 1 : 0;
            check("addr_x", int'(ram_addr_x), (h >> SS) & 255);
            check("addr_y", int'(ram_addr_y), (v >> SS) & 255);
            check("vga_r", int'(vga_r), er);
            check("vga_g", int'(vga_g), eg);
            check("vga_b", int'(vga_b), eb);
            check("hsync", int'(hsync), ehs);
            check("vsync", int'(vsync), evs);
            check("frame_start", int'(frame_start), efs);

            // Hand-computed anchors for the model.
            if (t == (7 * HT + 13) * PD) begin
                check("pin_addr_13_7_x", int'(ram_addr_x), 3);
                check("pin_addr_13_7_y", int'(ram_addr_y), 1);
            end
            if (t == (7 * HT + 14) * PD) begin
                check("pin_rgb_13_7_r", int'(vga_r), 15);
                check("pin_rgb_13_7_g", int'(vga_g), 0);
                check("pin_rgb_13_7_b", int'(vga_b), 15);
            end
            if (t == (19 * HT + 39) * PD) begin
                check("pin_addr_last_x", int'(ram_addr_x), 9);
                check("pin_addr_last_y", int'(ram_addr_y), 4);
            end
            if (t == (5 * HT + 41) * PD) begin
                check("pin_blank_h40", int'({vga_r, vga_g, vga_b}), 0);
            end
        end
    end

    // Pulse spacing and sync-width measurements.
    always @(negedge clk) begin
        if (started) begin
            cyc++;
            if (t == 0) begin
                last_fs = -1;
                hs_run  = 0;
                vs_run  = 0;
            end else begin
                if (frame_start) begin
                    fs_count++;
                    if (last_fs >= 0)
                        check("frame_spacing", cyc - last_fs, 6048);
                    last_fs = cyc;
                end
                if (!hsync) begin
                    hs_run++;
                end else if (hs_run > 0) begin
                    check("hsync_width", hs_run, 32);
                    hs_run = 0;
                end
                if (!vsync) begin
                    vs_run++;
                end else if (vs_run > 0) begin
                    check("vsync_width", vs_run, 448);
                    vs_run = 0;
                end
            end
        end
    end

    initial begin
        bit found;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[1 * 64 + 3]  = 16'hF81F;
        mem[0]           = 16'hFFFF;
        mem[1 * 64 + 10] = 16'hFFFF;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        started = 1'b1;
        rst = 1'b0;

        // Three uninterrupted frames.
        repeat (3 * FRAME + 200) @(negedge clk);
        check("frame_count", fs_count, 3);

        // Mid-frame reset held for 5 cycles.
        repeat ($urandom_range(100, 2000)) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
        check("rst_sync", int'({hsync, vsync}), 3);
        check("rst_addr", int'({ram_addr_x, ram_addr_y}), 0);
        check("rst_frame_start", int'(frame_start), 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("tick_not_early", int'(vga_r), 0);
        @(negedge clk);
        check("first_tick_r", int'(vga_r), 15);
        check("first_tick_g", int'(vga_g), 15);

        // Reset landing on a tick cycle while hsync is low.
        found = 1'b0;
        for (int i = 0; i < 4 * HT * PD; i++) begin
            @(negedge clk);
            if (t % PD == PD - 1 && (t / PD) % HT > HA + HF && (t / PD) % HT < HA + HF + HS) begin
                found = 1'b1;
                break;
            end
        end
        if (found) begin
            check("pre_rst_hsync", int'(hsync), 0);
            rst = 1'b1;
            @(negedge clk);
            check("tick_rst_hsync", int'(hsync), 1);
            check("tick_rst_addr", int'({ram_addr_x, ram_addr_y}), 0);
            check("tick_rst_frame_start", int'(frame_start), 0);
            rst = 1'b0;
        end else begin
            check("hsync_tick_search", 0, 1);
        end

        // Random reset bursts.
        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(200, 3000)) @(negedge clk);
            rst = 1'b1;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rst = 1'b0;
        end
        repeat (FRAME + 50) @(negedge clk);

        summary();
        $finish;
    end

endmodule
